wb_port_arbiter: RTL
====================

# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (MEM stage result) and completions from the long-latency multiply/divide unit. Drives the registered WB-stage write (`regwrite_WB`/`rd_WB`/`rd_data_WB`) and buffers muldiv results in a small FIFO. Raises a Moore stall to the hazard unit so buffered results always drain. Sits between the MEM stage, the muldiv unit and the register file.

## Interface
Parameters:
- `DEPTH`, 2: muldiv result buffer entries (≥1).
- `MAX_WAIT`, 4: consecutive pipeline grants tolerated while the buffer is non-empty (≥1).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `pipe_valid`  in  1  MEM stage requests a register write.
- `pipe_rd`  in  5  MEM stage destination.
- `pipe_data`  in  32  MEM stage write data.
- `md_valid`  in  1  muldiv result available.
- `md_rd`  in  5  muldiv destination.
- `md_data`  in  32  muldiv result.
- `md_ready`  out  1  result accepted this cycle when `md_valid & md_ready`.
- `stall_pipe`  out  1  MEM stage must hold; pipe inputs ignored.
- `busy_rd_mask`  out  32  one bit per rd held in the buffer (bit 0 always 0).
- `regwrite_WB`  out  1  registered write enable.
- `rd_WB`  out  5  registered destination.
- `rd_data_WB`  out  32  registered data.

## Operation
- Effective pipe request: `pipe_req = pipe_valid & (pipe_rd != 0) & ~stall_pipe`. Effective md request: `md_req = md_valid & md_ready & (md_rd != 0)`. A handshake with rd = 0 is accepted and discarded.
- `md_ready = (count < DEPTH) & (state != DRAIN)`.
- States:
  - IDLE: buffer empty.
    - `pipe_req` only: grant pipe.
    - `md_req` only: grant md directly, bypassing the buffer.
    - Both: grant pipe, push md, go to PIPE_PRI with `wait_cnt = 0`.
  - PIPE_PRI: buffer non-empty.
    - `pipe_req`: grant pipe; `wait_cnt++`.
    - Otherwise: pop the head to the output; `wait_cnt = 0`.
    - A push is allowed in the same cycle.
    - Next state: DRAIN if post-update `count == DEPTH` or `wait_cnt` reaches `MAX_WAIT`. Else IDLE if post-update `count == 0`. Else stay.
  - DRAIN: `stall_pipe = 1`. Pop the head every cycle; no pushes. Go to IDLE when post-pop `count == 0`; `wait_cnt` is cleared.
- `stall_pipe` is a pure function of state (Moore).
- No grant this cycle: `regwrite_WB` ← 0, `rd_WB`/`rd_data_WB` hold.
- The hazard unit guarantees no pipeline write to an rd set in `busy_rd_mask` or in flight in muldiv. The arbiter does not reorder same-rd writes.
- FIFO order is strictly preserved.

## Timing
- Reset values:
  - `regwrite_WB` = 0, `rd_WB` = 0, `rd_data_WB` = 0.
  - State = IDLE, `count` = 0, `wait_cnt` = 0.
  - Therefore `stall_pipe` = 0, `md_ready` = 1, `busy_rd_mask` = 0.
- Pipe and bypassed-md latency: 1 cycle, input to WB registers.
- Buffered md latency: ≥2 cycles. Upper bound is `MAX_WAIT + DEPTH + 1` cycles after push.
- `md_ready`, `stall_pipe` and `busy_rd_mask` are combinational from registered state only; there is no input-to-output combinational path.
- Simultaneous push and pop at `count == DEPTH` cannot occur, because `md_ready` is 0 when the buffer is full.
- Reset asserted mid-DRAIN discards buffer contents. The muldiv unit is reset by the same signal.

## Structure
- Package `riscvx_wb_pkg`: state enum (IDLE, PIPE_PRI, DRAIN) and `wb_req_t` struct {rd[4:0], data[31:0]}.
- Sub-module `wb_md_fifo`: `DEPTH`-entry circular FIFO with push/pop, count, head output and per-entry rd/valid for building the mask. Pointers wrap modulo `DEPTH`.
- Top level holds the FSM, `wait_cnt` and the WB output registers.

## Test plan
- Reset then pipe write (rd=5, data=0xDEADBEEF) -> next cycle `regwrite_WB`=1, `rd_WB`=5, `rd_data_WB`=0xDEADBEEF; `stall_pipe`=0 throughout.
- IDLE, md only (rd=7, 0x12345678) -> next cycle WB writes rd 7; `busy_rd_mask` never set.
- Same-cycle pipe (rd=3) and md (rd=9) -> WB rd 3; `busy_rd_mask[9]`=1. Next cycle with pipe idle -> WB rd 9, mask cleared, state IDLE.
- Buffer one md entry, then continuous pipe writes with `MAX_WAIT`=4 -> 4 pipe grants, then `stall_pipe`=1 for exactly 1 cycle while the md entry writes, then pipe resumes.
- Fill buffer (`DEPTH`=2) under continuous pipe traffic -> `md_ready`=0, `stall_pipe`=1 for 2 cycles draining entries in push order, then IDLE.
- md or pipe with rd=0 -> handshake completes, `regwrite_WB` stays 0; asserting `reset` during DRAIN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/riscvx_wb_pkg.sv
// Shared types for the register-file writeback arbiter.
package riscvx_wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPipePri,
    StDrain
  } wb_state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_md_fifo.sv
// Circular buffer for muldiv results waiting for the register-file write port.
module wb_md_fifo
  import riscvx_wb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  wb_req_t                      push_req_i,
  input  logic                         pop_i,
  output wb_req_t                      head_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic [Depth-1:0]             ent_valid_o,
  output logic [Depth-1:0][4:0]        ent_rd_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  wb_req_t          mem_q [Depth];
  logic [Depth-1:0] valid_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (pop_i) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_inc(rd_ptr_q);
      end
      if (push_i) begin
        mem_q[wr_ptr_q]   <= push_req_i;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_comb begin
    ent_rd_o = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      ent_rd_o[i] = mem_q[i].rd;
    end
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign ent_valid_o = valid_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the MEM stage and buffered
// muldiv completions, stalling the pipe when buffered results must drain.
module wb_port_arbiter
  import riscvx_wb_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        stall_pipe,
  output logic [31:0] busy_rd_mask,
  output logic        regwrite_WB,
  output logic [4:0]  rd_WB,
  output logic [31:0] rd_data_WB
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  wb_state_e        state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      data_q, data_d;

  logic             push, pop, pipe_req, md_req;
  logic [CntW-1:0]  count, count_post;
  wb_req_t          head;
  logic [DEPTH-1:0]      ent_valid;
  logic [DEPTH-1:0][4:0] ent_rd;

  wb_md_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_req_i  ({md_rd, md_data}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .ent_valid_o (ent_valid),
    .ent_rd_o    (ent_rd)
  );

  assign stall_pipe = (state_q == StDrain);
  assign md_ready   = (count < CntW'(DEPTH)) && (state_q != StDrain);
  assign pipe_req   = pipe_valid && (pipe_rd != 5'd0) && !stall_pipe;
  // rd = 0 handshakes complete but never reach the write port or buffer
  assign md_req     = md_valid && md_ready && (md_rd != 5'd0);

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    data_d     = data_q;
    push       = 1'b0;
    pop        = 1'b0;
    count_post = count;
    unique case (state_q)
      StIdle: begin
        if (pipe_req) begin
          regwrite_d = 1'b1;
          rd_d       = pipe_rd;
          data_d     = pipe_data;
          if (md_req) begin
            push    = 1'b1;
            wait_d  = '0;
            state_d = StPipePri;
          end
        end else if (md_req) begin
          regwrite_d = 1'b1;
          rd_d       = md_rd;
          data_d     = md_data;
        end
      end
      StPipePri: begin
        push       = md_req;
        regwrite_d = 1'b1;
        if (pipe_req) begin
          rd_d   = pipe_rd;
          data_d = pipe_data;
          wait_d = wait_q + 1'b1;
        end else begin
          pop    = 1'b1;
          rd_d   = head.rd;
          data_d = head.data;
          wait_d = '0;
        end
        count_post = count + CntW'(push) - CntW'(pop);
        if (count_post == CntW'(DEPTH) || wait_d == WaitW'(MAX_WAIT)) begin
          state_d = StDrain;
        end else if (count_post == '0) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        pop        = 1'b1;
        regwrite_d = 1'b1;
        rd_d       = head.rd;
        data_d     = head.data;
        count_post = count - 1'b1;
        if (count_post == '0) begin
          state_d = StIdle;
          wait_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    busy_rd_mask = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_valid[i]) begin
        busy_rd_mask[ent_rd[i]] = 1'b1;
      end
    end
    busy_rd_mask[0] = 1'b0;
  end

  assign regwrite_WB = regwrite_q;
  assign rd_WB       = rd_q;
  assign rd_data_WB  = data_q;

endmodule
